attn_score_mac: RTL and testbench

ATTN_SCORE_MAC -- requirements
Module: attn_score_mac

---
 rtl/attn_pkg.sv | 20 ++
 rtl/attn_exp_lut.sv | 34 +++
 rtl/attn_score_mac.sv | 165 ++++++++++++++++
 tb/tb_attn_score_mac.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/attn_pkg.sv
// Shared state encoding and default parameters for the attention score MAC.
// The EXP state only exists when SCORE_EXP_EN is defined.
package attn_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NFEAT    = 4;
  localparam int DEF_ROWS     = 4;
  localparam int DEF_SCALE_SH = 1;

  typedef enum logic [2:0] {
    LOAD_Q,
    LOAD_K,
    FINAL,
`ifdef SCORE_EXP_EN
    EXP,
`endif
    EMIT
  } state_e;

endpackage

// File: rtl/attn_exp_lut.sv
// Combinational e^x table: signed Q1.(DATA_W-2) score in, unsigned Q2.(DATA_W-2) out,
// saturated at 2^DATA_W-1. Only instantiated by attn_score_mac under SCORE_EXP_EN.
module attn_exp_lut #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] score_i,
  output logic [DATA_W-1:0] exp_o
);

  localparam int FULL = 1 << DATA_W;
  localparam int HALF = 1 << (DATA_W - 1);
  localparam int ONE  = 1 << (DATA_W - 2);

  // Entries are constant per index, so synthesis folds the real arithmetic into a ROM.
  function automatic logic [DATA_W-1:0] expEntry(input int idx);
    int  sVal;
    real v;
    int  r;
    sVal = (idx >= HALF) ? idx - FULL : idx;
    v    = $exp(real'(sVal) / real'(ONE)) * real'(ONE);
    r    = $rtoi($floor(v + 0.5));
    if (r > FULL - 1) r = FULL - 1;
    return r[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] table_w [FULL];

  for (genvar i = 0; i < FULL; i++) begin : g_tab
    assign table_w[i] = expEntry(i);
  end

  assign exp_o = table_w[score_i];

endmodule

// File: rtl/attn_score_mac.sv
// Streaming Q.K dot-product scorer: NFEAT interleaved Q/K elements in, one scaled,
// saturated score out per vector. Define SCORE_EXP_EN to emit e^score via attn_exp_lut.
module attn_score_mac
  import attn_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NFEAT    = DEF_NFEAT,
  parameter int ROWS     = DEF_ROWS,
  parameter int SCALE_SH = DEF_SCALE_SH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_vld,
  output logic              s_rdy,
  output logic [DATA_W-1:0] m_data,
  output logic              m_vld,
  input  logic              m_rdy,
  output logic              m_last
);

  localparam int PW = 2 * DATA_W;
  localparam int AW = 2 * DATA_W + $clog2(NFEAT) + 1;
  localparam int FW = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SH = DATA_W - 1 + SCALE_SH;

  localparam logic signed [AW-1:0] SAT_HI = (AW'(1) <<< (DATA_W - 1)) - AW'(1);
  localparam logic signed [AW-1:0] SAT_LO = -SAT_HI - AW'(1);

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] q_q, q_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [FW-1:0]            feat_q, feat_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [DATA_W-1:0] score_q, score_d;

  logic signed [PW-1:0]     qExt, kExt, prod;
  logic signed [AW-1:0]     prodExt, shifted;
  logic signed [DATA_W-1:0] satScore;
  logic                     sRdyRaw, mVldRaw;
  logic [DATA_W-1:0]        outData;

  assign qExt    = PW'(q_q);
  assign kExt    = PW'($signed(s_data));
  assign prod    = qExt * kExt;
  assign prodExt = {{(AW - PW){prod[PW-1]}}, prod};

  // Arithmetic shift floors toward -inf; the clamp keeps the score in DATA_W signed range.
  assign shifted = acc_q >>> SH;
  always_comb begin
    satScore = shifted[DATA_W-1:0];
    if (shifted > SAT_HI) begin
      satScore = SAT_HI[DATA_W-1:0];
    end else if (shifted < SAT_LO) begin
      satScore = SAT_LO[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_Q;
      q_q     <= '0;
      acc_q   <= '0;
      feat_q  <= '0;
      row_q   <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      feat_q  <= feat_d;
      row_q   <= row_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    acc_d   = acc_q;
    feat_d  = feat_q;
    row_d   = row_q;
    score_d = score_q;
    sRdyRaw = 1'b0;
    mVldRaw = 1'b0;
    unique case (state_q)
      LOAD_Q: begin
        sRdyRaw = 1'b1;
        if (s_vld) begin
          q_d     = $signed(s_data);
          state_d = LOAD_K;
        end
      end
      LOAD_K: begin
        sRdyRaw = 1'b1;
        if (s_vld) begin
          acc_d = acc_q + prodExt;
          if (feat_q == FW'(NFEAT - 1)) begin
            feat_d  = '0;
            state_d = FINAL;
          end else begin
            feat_d  = feat_q + FW'(1);
            state_d = LOAD_Q;
          end
        end
      end
      FINAL: begin
        score_d = satScore;
        acc_d   = '0;
`ifdef SCORE_EXP_EN
        state_d = EXP;
`else
        state_d = EMIT;
`endif
      end
`ifdef SCORE_EXP_EN
      EXP: begin
        state_d = EMIT;
      end
`endif
      EMIT: begin
        mVldRaw = 1'b1;
        if (m_rdy) begin
          state_d = LOAD_Q;
          row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        end
      end
      default: begin
        state_d = LOAD_Q;
      end
    endcase
  end

`ifdef SCORE_EXP_EN
  logic [DATA_W-1:0] exp_w;
  logic [DATA_W-1:0] mdata_q;

  attn_exp_lut #(
    .DATA_W (DATA_W)
  ) u_exp (
    .score_i (score_q),
    .exp_o   (exp_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mdata_q <= '0;
    end else if (state_q == EXP) begin
      mdata_q <= exp_w;
    end
  end

  assign outData = mdata_q;
`else
  assign outData = score_q;
`endif

  // Outputs are forced idle whenever reset is asserted, even before the first edge.
  assign s_rdy  = sRdyRaw & ~rst;
  assign m_vld  = mVldRaw & ~rst;
  assign m_last = m_vld & (row_q == RW'(ROWS - 1));
  assign m_data = rst ? '0 : outData;

endmodule

// File: tb/tb_attn_score_mac.sv
// Randomised and directed bench for attn_score_mac, checked against a dot-product model.
module tb_attn_score_mac;

  localparam int DATA_W   = 8;
  localparam int NF       = 4;
  localparam int ROWS     = 4;
  localparam int SCALE_SH = 1;
  localparam int BUDGET   = 200;

`ifdef SCORE_EXP_EN
  localparam int LAT        = 3;
  localparam int EXP_ZERO   = 64;
  localparam int EXP_64     = 174;
  localparam int EXP_SAT_HI = 255;
  localparam int EXP_SAT_LO = 9;
  localparam int EXP_16     = 82;
`else
  localparam int LAT        = 2;
  localparam int EXP_ZERO   = 0;
  localparam int EXP_64     = 64;
  localparam int EXP_SAT_HI = 127;
  localparam int EXP_SAT_LO = 128;
  localparam int EXP_16     = 16;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_vld = 1'b0;
  logic              s_rdy;
  logic [DATA_W-1:0] m_data;
  logic              m_vld;
  logic              m_rdy;
  logic              m_last;

  int checks = 0;
  int failures = 0;
  int rdyMode = 1;

  int elems[$];
  int expQ[$];
  int outCount = 0;

  attn_score_mac #(
    .DATA_W   (DATA_W),
    .NFEAT    (NF),
    .ROWS     (ROWS),
    .SCALE_SH (SCALE_SH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_vld  (s_vld),
    .s_rdy  (s_rdy),
    .m_data (m_data),
    .m_vld  (m_vld),
    .m_rdy  (m_rdy),
    .m_last (m_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: exact integer dot product, floor division by 2^(DATA_W-1+SCALE_SH), clamp.
  function automatic int modelOut();
    longint sum = 0;
    longint dv  = longint'(1) << (DATA_W - 1 + SCALE_SH);
    longint quo;
    for (int i = 0; i < NF; i++) sum += longint'(elems[2*i]) * longint'(elems[2*i+1]);
    quo = sum / dv;
    if ((sum % dv != 0) && (sum < 0)) quo -= 1;
    if (quo > 127) quo = 127;
    if (quo < -128) quo = -128;
`ifdef SCORE_EXP_EN
    begin
      real v;
      int  r;
      v = $exp(real'(quo) / 64.0) * 64.0;
      r = $rtoi($floor(v + 0.5));
      if (r > 255) r = 255;
      return r;
    end
`else
    return int'(quo) & 255;
`endif
  endfunction

  initial begin
    m_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdyMode)
        0:       m_rdy = 1'b0;
        1:       m_rdy = 1'b1;
        default: m_rdy = 1'($urandom_range(1));
      endcase
    end
  end

  initial begin
    logic       prevStall;
    logic [7:0] prevData;
    int         e;
    prevStall = 1'b0;
    prevData  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        elems.delete();
        expQ.delete();
        outCount  = 0;
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("holdVld", int'(m_vld), 1);
          checkOutput("holdData", int'(m_data), int'(prevData));
          checkOutput("holdSrdy", int'(s_rdy), 0);
        end
        if (!m_vld) checkOutput("lastIdle", int'(m_last), 0);
        if (m_vld && m_rdy) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedScore", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("scoreData", int'(m_data), e);
            checkOutput("scoreLast", int'(m_last), int'((outCount % ROWS) == ROWS - 1));
            outCount++;
          end
        end
        if (s_vld && s_rdy) begin
          elems.push_back(int'($signed(s_data)));
          if (elems.size() == 2 * NF) begin
            expQ.push_back(modelOut());
            elems.delete();
          end
        end
        prevStall = m_vld && !m_rdy;
        prevData  = m_data;
      end
    end
  end

  task automatic sendElem(input logic [DATA_W-1:0] v, input int gapMax);
    int n;
    int gap;
    gap = (gapMax > 0) ? int'($urandom_range(gapMax)) : 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_data = v;
    s_vld  = 1'b1;
    n      = 0;
    @(negedge clk);
    while (!s_rdy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!s_rdy) checkOutput("inputTimeout", 0, 1);
    @(posedge clk);
    #1;
    s_vld = 1'b0;
  endtask

  task automatic applyStimulus(input int qv[NF], input int kv[NF], input int gapMax);
    for (int i = 0; i < NF; i++) begin
      sendElem(8'(qv[i]), gapMax);
      sendElem(8'(kv[i]), gapMax);
    end
  endtask

  task automatic waitVld();
    int n;
    n = 0;
    @(negedge clk);
    while (!m_vld && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!m_vld) checkOutput("outputTimeout", 0, 1);
  endtask

  task automatic checkLatency(input string name, input int expData);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      checkOutput({name, "Latency"}, int'(m_vld), int'(i == LAT));
      if (i < LAT) @(posedge clk);
    end
    checkOutput({name, "Data"}, int'(m_data), expData);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rstSrdy", int'(s_rdy), 0);
    checkOutput("rstMvld", int'(m_vld), 0);
    checkOutput("rstMlast", int'(m_last), 0);
    checkOutput("rstMdata", int'(m_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("srdyAfterReset", int'(s_rdy), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int qv[NF];
    int kv[NF];
    int lastSeen[5];
    int r;

    #1;
    doReset();

    foreach (qv[i]) begin qv[i] = 0; kv[i] = 0; end
    applyStimulus(qv, kv, 0);
    checkLatency("zeroVec", EXP_ZERO);

    foreach (qv[i]) begin qv[i] = 64; kv[i] = 64; end
    applyStimulus(qv, kv, 0);
    checkLatency("vec64", EXP_64);

    foreach (qv[i]) begin qv[i] = -128; kv[i] = -128; end
    applyStimulus(qv, kv, 0);
    checkLatency("satHigh", EXP_SAT_HI);

    foreach (qv[i]) begin qv[i] = -128; kv[i] = 127; end
    applyStimulus(qv, kv, 0);
    checkLatency("satLow", EXP_SAT_LO);

    rdyMode = 0;
    foreach (qv[i]) begin qv[i] = 64; kv[i] = 64; end
    applyStimulus(qv, kv, 0);
    waitVld();
    @(posedge clk);
    #1;
    s_data = 8'h55;
    s_vld  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stallVld", int'(m_vld), 1);
      checkOutput("stallData", int'(m_data), EXP_64);
      checkOutput("stallSrdy", int'(s_rdy), 0);
      @(posedge clk);
      #1;
    end
    s_vld   = 1'b0;
    rdyMode = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("resumeSrdy", int'(s_rdy), 1);
    checkOutput("resumeMvld", int'(m_vld), 0);
    @(posedge clk);
    #1;

    doReset();
    for (int n = 0; n < 5; n++) begin
      foreach (qv[i]) begin qv[i] = int'($urandom_range(255)) - 128; kv[i] = int'($urandom_range(255)) - 128; end
      applyStimulus(qv, kv, 1);
      waitVld();
      lastSeen[n] = int'(m_last);
      @(posedge clk);
      #1;
    end
    for (int n = 0; n < 5; n++) checkOutput("rowLast", lastSeen[n], int'(n == 3));

    for (int i = 0; i < 3; i++) begin
      sendElem(8'd100, 0);
      sendElem(8'd100, 0);
    end
    doReset();
    foreach (qv[i]) begin qv[i] = 32; kv[i] = 32; end
    applyStimulus(qv, kv, 0);
    checkLatency("afterReset", EXP_16);

    rdyMode = 2;
    for (int n = 0; n < 200; n++) begin
      foreach (qv[i]) begin
        r     = int'($urandom_range(9));
        qv[i] = (r == 0) ? -128 : (r == 1) ? 127 : int'($urandom_range(255)) - 128;
        r     = int'($urandom_range(9));
        kv[i] = (r == 0) ? -128 : (r == 1) ? 127 : int'($urandom_range(255)) - 128;
      end
      applyStimulus(qv, kv, 2);
    end
    rdyMode = 1;
    repeat (20) @(posedge clk);
    checkOutput("drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
